// File: rtl/q100_decode_pipe_if.sv
// q100 decode pipe: bundle of the IF->ID input bus, the write-back
// port and the ID->EX output bus.
interface q100_decode_pipe_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RW   = $clog2(NREG)
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [XLEN-1:0]      pc_i;
    logic [RW-1:0]        rs1_i;
    logic [RW-1:0]        rs2_i;
    logic [RW-1:0]        rd_i;
    logic [2:0]           funct3_i;
    logic [6:0]           funct7_i;
    logic [XLEN-1:0]      imm_i;
    logic [6:0]           opcode_i;
    logic [NREG*XLEN-1:0] xn_i;
    logic                 reg_wr_WB_i;
    logic [RW-1:0]        rd_WB_i;
    logic [XLEN-1:0]      xn_result_WB_i;
    logic                 flush_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 WB_o;
    logic                 M_o;
    logic                 EX_o;
    logic                 CSR_o;
    logic [XLEN-1:0]      pc_o;
    logic [XLEN-1:0]      xn_rs1_o;
    logic [XLEN-1:0]      xn_rs2_o;
    logic [XLEN-1:0]      imm_o;
    logic [RW-1:0]        rs1_o;
    logic [RW-1:0]        rs2_o;
    logic [RW-1:0]        rd_o;
    logic [2:0]           funct3_o;
    logic [6:0]           funct7_o;
    logic [6:0]           opcode_o;
    logic                 hazard_o;

    // Fetch / write-back / execute side
    modport master (
        output in_valid_i, pc_i, rs1_i, rs2_i, rd_i,
        output funct3_i, funct7_i, imm_i, opcode_i, xn_i,
        output reg_wr_WB_i, rd_WB_i, xn_result_WB_i,
        output flush_i, out_ready_i,
        input  in_ready_o, out_valid_o,
        input  WB_o, M_o, EX_o, CSR_o,
        input  pc_o, xn_rs1_o, xn_rs2_o, imm_o,
        input  rs1_o, rs2_o, rd_o,
        input  funct3_o, funct7_o, opcode_o, hazard_o
    );

    // Decode stage side
    modport slave (
        input  in_valid_i, pc_i, rs1_i, rs2_i, rd_i,
        input  funct3_i, funct7_i, imm_i, opcode_i, xn_i,
        input  reg_wr_WB_i, rd_WB_i, xn_result_WB_i,
        input  flush_i, out_ready_i,
        output in_ready_o, out_valid_o,
        output WB_o, M_o, EX_o, CSR_o,
        output pc_o, xn_rs1_o, xn_rs2_o, imm_o,
        output rs1_o, rs2_o, rd_o,
        output funct3_o, funct7_o, opcode_o, hazard_o
    );
endinterface

// File: rtl/q100_decode_pipe.sv
// q100 decode stage: one ID/EX output register with operand read,
// write-back bypass, load-use bubble insertion and flush.
module q100_decode_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RW   = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst,
    q100_decode_pipe_if.slave  bus
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic            wb;
        logic            m;
        logic            ex;
        logic            csr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1v;
        logic [XLEN-1:0] rs2v;
        logic [XLEN-1:0] imm;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [6:0]      opcode;
    } id_ex_t;

    state_t state_q, state_d;
    id_ex_t id_ex_q, id_ex_d;
    id_ex_t dec;

    logic full;
    logic hazard;
    logic in_ready;
    logic accept;
    logic xfer;
    logic hit_rs1;
    logic hit_rs2;

    // x0 reads as zero; a same-cycle write-back wins over the file
    function automatic logic [XLEN-1:0] read_op(
        input logic [RW-1:0]        idx,
        input logic [NREG*XLEN-1:0] xn,
        input logic                 wr,
        input logic [RW-1:0]        wa,
        input logic [XLEN-1:0]      wd
    );
        if (idx == '0)
            read_op = '0;
        else if (wr && wa == idx)
            read_op = wd;
        else
            read_op = xn[int'(idx)*XLEN +: XLEN];
    endfunction

    assign full = (state_q == FULL);

    // Load-use: the held load writes a register the incoming one reads
    assign hazard = bus.in_valid_i && full &&
                    id_ex_q.opcode == OP_LOAD &&
                    id_ex_q.rd != '0 &&
                    (id_ex_q.rd == bus.rs1_i ||
                     id_ex_q.rd == bus.rs2_i) &&
                    !bus.flush_i;

    assign in_ready = (!full || bus.out_ready_i) &&
                      !hazard && !bus.flush_i;
    assign accept   = bus.in_valid_i && in_ready;
    assign xfer     = full && bus.out_ready_i;

    // Held-instruction bypass from write-back while stalled
    assign hit_rs1 = bus.reg_wr_WB_i && bus.rd_WB_i != '0 &&
                     bus.rd_WB_i == id_ex_q.rs1 &&
                     id_ex_q.opcode != OP_AUIPC;
    assign hit_rs2 = bus.reg_wr_WB_i && bus.rd_WB_i != '0 &&
                     bus.rd_WB_i == id_ex_q.rs2;

    // Decode the incoming instruction into an ID/EX bundle
    always_comb begin
        dec        = '0;
        dec.pc     = bus.pc_i;
        dec.imm    = bus.imm_i;
        dec.rs1    = bus.rs1_i;
        dec.rs2    = bus.rs2_i;
        dec.rd     = bus.rd_i;
        dec.funct3 = bus.funct3_i;
        dec.funct7 = bus.funct7_i;
        dec.opcode = bus.opcode_i;
        dec.rs1v   = read_op(bus.rs1_i, bus.xn_i, bus.reg_wr_WB_i,
                             bus.rd_WB_i, bus.xn_result_WB_i);
        dec.rs2v   = read_op(bus.rs2_i, bus.xn_i, bus.reg_wr_WB_i,
                             bus.rd_WB_i, bus.xn_result_WB_i);
        unique case (bus.opcode_i)
            OP_LUI: begin
                dec.wb = 1'b1;
                dec.ex = 1'b1;
            end
            OP_AUIPC: begin
                dec.wb   = 1'b1;
                dec.ex   = 1'b1;
                dec.rs1v = bus.pc_i;
            end
            OP_JAL, OP_JALR: begin
                dec.wb = 1'b1;
            end
            OP_LOAD: begin
                dec.wb = 1'b1;
                dec.m  = 1'b1;
                dec.ex = 1'b1;
            end
            OP_STORE: begin
                dec.m  = 1'b1;
                dec.ex = 1'b1;
            end
            OP_OPIMM, OP_OP: begin
                dec.wb = 1'b1;
                dec.ex = 1'b1;
            end
            OP_SYSTEM: begin
                dec.csr = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Next state: flush beats accept, accept beats drain
    always_comb begin
        state_d = state_q;
        if (bus.flush_i)
            state_d = EMPTY;
        else if (accept)
            state_d = FULL;
        else if (xfer)
            state_d = EMPTY;
    end

    // Next ID/EX contents; an empty register is all zero
    always_comb begin
        id_ex_d = id_ex_q;
        if (bus.flush_i) begin
            id_ex_d = '0;
        end else if (accept) begin
            id_ex_d = dec;
        end else if (xfer) begin
            id_ex_d = '0;
        end else if (full) begin
            if (hit_rs1)
                id_ex_d.rs1v = bus.xn_result_WB_i;
            if (hit_rs2)
                id_ex_d.rs2v = bus.xn_result_WB_i;
        end
    end

    // State and output register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            id_ex_q <= '0;
        end else begin
            state_q <= state_d;
            id_ex_q <= id_ex_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.hazard_o    = hazard;
    assign bus.out_valid_o = full;
    assign bus.WB_o        = full && id_ex_q.wb;
    assign bus.M_o         = full && id_ex_q.m;
    assign bus.EX_o        = full && id_ex_q.ex;
    assign bus.CSR_o       = full && id_ex_q.csr;
    assign bus.pc_o        = id_ex_q.pc;
    assign bus.xn_rs1_o    = id_ex_q.rs1v;
    assign bus.xn_rs2_o    = id_ex_q.rs2v;
    assign bus.imm_o       = id_ex_q.imm;
    assign bus.rs1_o       = id_ex_q.rs1;
    assign bus.rs2_o       = id_ex_q.rs2;
    assign bus.rd_o        = id_ex_q.rd;
    assign bus.funct3_o    = id_ex_q.funct3;
    assign bus.funct7_o    = id_ex_q.funct7;
    assign bus.opcode_o    = id_ex_q.opcode;

endmodule
